// File: rtl/x_pattern_serializer_if.sv
// ---------------------------------------------------------------------------
// x_pattern_serializer_if
//   Bundles the pattern handshake and serial-output signals of
//   x_pattern_serializer.
//   master : pattern producer (drives in_valid/in_data/in_len, observes the rest)
//   slave  : the serializer itself
//   Signals:
//     in_valid    pattern offered
//     in_ready    serializer can accept a pattern
//     in_data     pattern bits, low L bits are sent MSB-first
//     in_len      pattern length L (0 or >WIDTH means WIDTH)
//     x           serial bit
//     x_valid     x carries a pattern bit
//     frame_start x shows the first bit of a pattern
//     frame_end   x shows the last bit of a pattern
//     busy        shifter active or hold buffer full
// ---------------------------------------------------------------------------
interface x_pattern_serializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       in_len;
  logic             x;
  logic             x_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output in_valid, in_data, in_len,
    input  in_ready, x, x_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  in_valid, in_data, in_len,
    output in_ready, x, x_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/x_pattern_serializer.sv
// ---------------------------------------------------------------------------
// x_pattern_serializer
//   Accepts parallel bit patterns over a valid/ready handshake and shifts them
//   out MSB-first, one bit per clock, on the serial line x. A one-entry hold
//   buffer accepts the next pattern while the current one shifts, so
//   back-to-back patterns form a gap-free bit stream.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  slave side of x_pattern_serializer_if (handshake + serial outputs)
//   Parameters:
//     WIDTH   maximum pattern length, 1..15
//     IDLE_X  level on x while no pattern is shifting
// ---------------------------------------------------------------------------
module x_pattern_serializer #(
  parameter int   WIDTH  = 8,
  parameter logic IDLE_X = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  x_pattern_serializer_if.slave  bus
);

  localparam logic [3:0] WIDTH4 = 4'(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [3:0]       rem, rem_nxt;
  logic [3:0]       len_q, len_nxt;
  logic             hold_valid, hold_valid_nxt;
  logic [WIDTH-1:0] hold_data, hold_data_nxt;
  logic [3:0]       hold_len, hold_len_nxt;

  logic             accept;
  logic             frame_done;
  logic [3:0]       in_len_c;

  // Lengths of 0 or beyond WIDTH mean a full-width pattern.
  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    if (l == 4'd0 || l > WIDTH4) return WIDTH4;
    return l;
  endfunction

  // Left-justify the low l bits so the first bit to send sits in the MSB.
  function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] d,
                                             input logic [3:0]       l);
    return d << (WIDTH4 - l);
  endfunction

  assign bus.in_ready = !hold_valid && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign in_len_c     = clamp_len(bus.in_len);
  // The shifter can take a new word on this edge: either idle, or its last
  // bit is on the line now.
  assign frame_done   = (state == IDLE) || (rem == 4'd1);

  always_comb begin
    state_nxt      = state;
    sh_nxt         = sh;
    rem_nxt        = rem;
    len_nxt        = len_q;
    hold_valid_nxt = hold_valid;
    hold_data_nxt  = hold_data;
    hold_len_nxt   = hold_len;

    if (frame_done) begin
      if (hold_valid) begin
        // in_ready is low here, so no accept can collide with the refill.
        sh_nxt         = align(hold_data, hold_len);
        rem_nxt        = hold_len;
        len_nxt        = hold_len;
        hold_valid_nxt = 1'b0;
      end else if (accept) begin
        sh_nxt  = align(bus.in_data, in_len_c);
        rem_nxt = in_len_c;
        len_nxt = in_len_c;
      end else begin
        if (state == SHIFT) sh_nxt = sh << 1;
        rem_nxt = 4'd0;
      end
    end else begin
      sh_nxt  = sh << 1;
      rem_nxt = rem - 4'd1;
      if (accept) begin
        hold_valid_nxt = 1'b1;
        hold_data_nxt  = bus.in_data;
        hold_len_nxt   = in_len_c;
      end
    end

    state_nxt = (rem_nxt != 4'd0) ? SHIFT : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sh         <= '0;
      rem        <= 4'd0;
      len_q      <= 4'd0;
      hold_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      sh         <= sh_nxt;
      rem        <= rem_nxt;
      len_q      <= len_nxt;
      hold_valid <= hold_valid_nxt;
    end
  end

  // Hold payload is qualified by hold_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_data <= hold_data_nxt;
    hold_len  <= hold_len_nxt;
  end

  assign bus.x           = (state == SHIFT) ? sh[WIDTH-1] : IDLE_X;
  assign bus.x_valid     = (state == SHIFT);
  assign bus.frame_start = (state == SHIFT) && (rem == len_q);
  assign bus.frame_end   = (state == SHIFT) && (rem == 4'd1);
  assign bus.busy        = (rem != 4'd0) || hold_valid;

endmodule

// File: tb/tb_x_pattern_serializer.sv
// ---------------------------------------------------------------------------
// tb_x_pattern_serializer
//   Directed bench for x_pattern_serializer (WIDTH=8, IDLE_X=0): reset,
//   single frame, back-to-back frames through the hold buffer, length edge
//   cases, reset mid-frame, and a randomized handshake run against a
//   bit-level scoreboard.
// ---------------------------------------------------------------------------
module tb_x_pattern_serializer;

  logic clk = 1'b0;
  logic rst;

  x_pattern_serializer_if #(.WIDTH(8)) bus ();

  x_pattern_serializer #(.WIDTH(8), .IDLE_X(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic b;
    logic fs;
    logic fe;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;
  bit  sb_en = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a word and wait for the handshake; returns 1 ns after the accepting
  // edge, i.e. while the first bit of an idle-loaded word is on x.
  task automatic send(input logic [7:0] d, input logic [3:0] l, input bit track);
    int  n;
    int  len;
    bit  rdy;
    bit  done;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_len   = l;
    n    = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (rdy) done = 1'b1;
    end
    bus.in_valid = 1'b0;
    chk("accept_timeout", done, 1'b1);
    if (done && track) begin
      len = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
      for (int i = len - 1; i >= 0; i--)
        q.push_back('{d[i], (i == len - 1), (i == 0)});
    end
  endtask

  task automatic run_frame(input string tag, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_x"},       bus.x,           bits[n-1-i]);
      chk({tag, "_x_valid"}, bus.x_valid,     1'b1);
      chk({tag, "_fs"},      bus.frame_start, (i == 0));
      chk({tag, "_fe"},      bus.frame_end,   (i == n - 1));
      step();
    end
    chk({tag, "_idle_x"},       bus.x,       1'b0);
    chk({tag, "_idle_x_valid"}, bus.x_valid, 1'b0);
    chk({tag, "_idle_busy"},    bus.busy,    1'b0);
  endtask

  // Scoreboard monitor: x_valid must be high exactly while accepted bits are
  // still owed, which also rules out gaps between queued patterns.
  always @(negedge clk) begin
    if (sb_en) begin
      chk("sb_x_valid", bus.x_valid, (q.size() != 0));
      if (bus.x_valid && q.size() != 0) begin
        mon_e = q.pop_front();
        chk("sb_x",  bus.x,           mon_e.b);
        chk("sb_fs", bus.frame_start, mon_e.fs);
        chk("sb_fe", bus.frame_end,   mon_e.fe);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ab_bits;
    int          n;
    int          gap;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_len   = 4'd0;

    // Reset held for two edges
    #1;
    chk("rst_x",        bus.x,           1'b0);
    chk("rst_x_valid",  bus.x_valid,     1'b0);
    chk("rst_in_ready", bus.in_ready,    1'b0);
    chk("rst_busy",     bus.busy,        1'b0);
    chk("rst_fs",       bus.frame_start, 1'b0);
    chk("rst_fe",       bus.frame_end,   1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_in_ready", bus.in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", bus.in_ready, 1'b1);
    chk("rel_busy",     bus.busy,     1'b0);
    step();

    // Single frame 0x3A, length 7 -> 0111010
    send(8'h3A, 4'd7, 1'b0);
    run_frame("single", 16'h003A, 7);

    // Back-to-back: A5/8 then 0F/4 through the hold buffer
    ab_bits = 12'hA5F;
    send(8'hA5, 4'd8, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h0F;
    bus.in_len   = 4'd4;
    for (int i = 0; i < 12; i++) begin
      chk("b2b_x",       bus.x,           ab_bits[11-i]);
      chk("b2b_x_valid", bus.x_valid,     1'b1);
      chk("b2b_fs",      bus.frame_start, (i == 0 || i == 8));
      chk("b2b_fe",      bus.frame_end,   (i == 7 || i == 11));
      if (i == 1) begin
        chk("b2b_in_ready_held", bus.in_ready, 1'b0);
        chk("b2b_busy",          bus.busy,     1'b1);
      end
      if (i == 8) chk("b2b_in_ready_freed", bus.in_ready, 1'b1);
      step();
      if (i == 0) bus.in_valid = 1'b0;
    end
    chk("b2b_after_x_valid", bus.x_valid, 1'b0);
    chk("b2b_after_busy",    bus.busy,    1'b0);

    // Length edge cases
    send(8'h81, 4'd0, 1'b0);
    run_frame("len0", 16'h0081, 8);
    send(8'hC3, 4'd12, 1'b0);
    run_frame("len12", 16'h00C3, 8);
    send(8'h01, 4'd1, 1'b0);
    run_frame("len1", 16'h0001, 1);

    // Reset during bit 3 of 0xFF with a word waiting in hold
    send(8'hFF, 4'd8, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    bus.in_len   = 4'd8;
    step();
    bus.in_valid = 1'b0;
    chk("mid_hold_full", bus.in_ready, 1'b0);
    step();
    chk("mid_bit3_x", bus.x, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_x",        bus.x,           1'b0);
    chk("mid_rst_x_valid",  bus.x_valid,     1'b0);
    chk("mid_rst_fs",       bus.frame_start, 1'b0);
    chk("mid_rst_fe",       bus.frame_end,   1'b0);
    chk("mid_rst_busy",     bus.busy,        1'b0);
    chk("mid_rst_in_ready", bus.in_ready,    1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("mid_after_x",       bus.x,       1'b0);
      chk("mid_after_x_valid", bus.x_valid, 1'b0);
      step();
    end
    chk("mid_after_busy", bus.busy, 1'b0);

    // Randomized handshake against the scoreboard
    sb_en = 1'b1;
    for (int w = 0; w < 200; w++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      for (int g = 0; g < gap; g++) step();
      send(8'($urandom), 4'($urandom_range(0, 15)), 1'b1);
    end
    n = 0;
    while (q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    chk("stress_drained", (q.size() == 0), 1'b1);
    step();
    sb_en = 1'b0;
    chk("stress_end_x_valid", bus.x_valid, 1'b0);
    chk("stress_end_busy",    bus.busy,    1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/x_pattern_serializer.md
# x_pattern_serializer

- Upstream stimulus stage for the Mealy sequence FSM.
- Accepts parallel bit patterns over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on the serial line `x` that the FSM samples.
- A one-entry holding buffer lets the next pattern be accepted while the current one shifts, so consecutive patterns produce a gap-free bit stream.

## Interface

- WIDTH, default 8: maximum pattern length in bits; legal range 1..15.
- IDLE_X, default 1'b0: level driven on `x` when no pattern is shifting.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  pattern offered
- in_ready  out  1  holding buffer can accept; transfer when in_valid && in_ready at a rising edge
- in_data  in  WIDTH  pattern; the low L bits are sent, bit L-1 first
- in_len  in  4  pattern length L; 0 or >WIDTH means WIDTH
- x  out  1  serial bit to the FSM
- x_valid  out  1  `x` carries a pattern bit this cycle
- frame_start  out  1  high during the cycle `x` shows a pattern's first bit
- frame_end  out  1  high during the cycle `x` shows a pattern's last bit
- busy  out  1  active shifter loaded or hold buffer full

## Operation

- Storage:
  - active shift register `sh[WIDTH-1:0]`
  - remaining-bit counter `rem` (4 bits)
  - hold buffer `{hold_valid, hold_data, hold_len}`
- States:
  - IDLE (rem==0)
  - SHIFT (rem>0)
- Load on accept:
  - L is clamped per the in_len rule.
  - Load writes `sh <= in_data << (WIDTH-L)` and `rem <= L`.
- Outputs:
  - In SHIFT: `x = sh[WIDTH-1]`, `x_valid = 1`.
  - In IDLE: `x = IDLE_X`, `x_valid = 0`.
  - `frame_start = (rem == loaded L)`.
  - `frame_end = (rem == 1)`.
  - L=1 asserts both in the same cycle.
- Each SHIFT edge: `sh <= sh << 1`, `rem <= rem-1`.
- On the edge where rem==1 (last bit):
  - if hold_valid: load from hold and clear hold_valid → SHIFT continues with no idle cycle;
  - else: → IDLE.
- `in_ready = !hold_valid && !rst`.
- Accepted word routing:
  - In IDLE with hold empty: the accepted word bypasses hold and loads the shifter directly.
  - Otherwise it is written into hold.
- Simultaneous events:
  - If an accept and a last-bit edge coincide while hold is empty, the incoming word loads the shifter directly; hold stays empty.
  - A hold refill and a new accept in the same edge cannot occur, because in_ready was low.
- A word is consumed exactly once per handshake. Holding in_valid high while in_ready is low must not duplicate or drop data.
- `busy = (rem != 0) || hold_valid`.

## Timing

- Reset values (asynchronous):
  - `rem=0`, `sh=0`, `hold_valid=0`
  - `x=IDLE_X`, `x_valid=0`, `frame_start=0`, `frame_end=0`, `busy=0`, `in_ready=0`
- `in_ready` rises in the first cycle after rst deasserts.
- Latency: a word accepted at edge N into an idle block shows its first bit during cycle N→N+1 and its last bit during cycle N+L-1→N+L.
- A word accepted into hold is shown starting the cycle right after the current frame's last bit.
- `x` changes only just after rising edges and is stable for the FSM's next sampling edge.
- Reset mid-frame: `x`, `x_valid` and flags go to their reset values immediately. Shifter and hold contents are discarded. No residual bits appear after release.
- Throughput: one bit per cycle sustained indefinitely while in_valid keeps hold filled.

## Test plan

- Reset: rst=1 for 2 cycles → x=0, x_valid=0, in_ready=0, busy=0; after release in_ready=1 within one cycle.
- Single frame: in_data=8'h3A, in_len=7 accepted at edge N → x over the next 7 cycles = 0,1,1,1,0,1,0; frame_start in cycle 1 only, frame_end in cycle 7 only; then x=0, x_valid=0, busy=0.
- Back-to-back: A=8'hA5/len 8, then B=8'h0F/len 4 held valid → B waits in hold (in_ready=0) → x = 1,0,1,0,0,1,0,1,1,1,1,1 contiguous; x_valid high 12 cycles; frame_start at cycles 1 and 9; frame_end at cycles 8 and 12.
- Length edges:
  - len 0 with 8'h81 → 8 bits 1,0,0,0,0,0,0,1.
  - len 12 → clamped to 8.
  - len 1, data 1 → one bit, frame_start=frame_end=1 in the same cycle.
- Reset mid-frame: assert rst during bit 3 of 8'hFF with a word in hold → x=0, x_valid=0 immediately; after release, zero further bits until a new handshake.
- Handshake stress: randomized in_valid for 200 words with a scoreboard → serial output equals the concatenated clamped patterns; no duplicates, no drops, no idle gap whenever hold was full at a last-bit edge.
